// File: rtl/cga_pkg.sv
// ============================================================================
// cga_pkg : shared types and constants for the CGA VRAM fetch block
// Revision: 1.0
// ============================================================================
`default_nettype none

package cga_pkg;

   localparam int ADDR_W_DEF  = 14;
   localparam int FETCH_LAT   = 2;
   localparam int HRES_STRIDE = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WAIT  = 3'd1,
      ST_ISSUE = 3'd2,
      ST_LAT   = 3'd3,
      ST_ACK   = 3'd4
   } cpu_state_e;

   // True when the sequencer slot belongs to the display fetch engine.
   function automatic logic slot_reserved(input logic [4:0] seq,
                                          input logic [4:0] f,
                                          input logic       hres);
      logic [4:0] h;
      h = f + 5'(HRES_STRIDE);
      return (seq == f) || (seq == f + 5'd1) ||
             (hres && ((seq == h) || (seq == h + 5'd1)));
   endfunction

endpackage

`default_nettype wire

// File: rtl/cga_vram_fetch.sv
// ============================================================================
// cga_vram_fetch : display char/attr fetch plus CPU access arbitration on VRAM.
// Optional CGA_SNOW_EN lets the CPU steal hres text char slots (snow).
// Revision: 1.0
// ============================================================================
`default_nettype none

module cga_vram_fetch
   import cga_pkg::*;
#(
   parameter logic [4:0] SLOT_CHAR = 5'd0,
   parameter int         ADDR_W    = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [4:0]        clk_seq,
   input  logic              hres_mode,
   input  logic              grph_mode,
   input  logic [12:0]       crtc_addr,
   input  logic [4:0]        row_addr,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_wdata,
   output logic              cpu_busy,
   output logic              cpu_ack,
   output logic [7:0]        cpu_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [7:0]        ram_wdata,
   input  logic [7:0]        ram_rdata,
   output logic [7:0]        vram_data,
   output logic              vram_read_char,
   output logic              vram_read_att
);

   localparam logic [4:0] F0 = SLOT_CHAR;
   localparam logic [4:0] F1 = SLOT_CHAR + 5'd1;
   localparam logic [4:0] H0 = SLOT_CHAR + 5'(HRES_STRIDE);
   localparam logic [4:0] H1 = H0 + 5'd1;

   cpu_state_e           state_q, state_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic                 we_q, we_d;
   logic [7:0]           wdata_q, wdata_d;
   logic [7:0]           vram_data_q, vram_data_d;
   logic [7:0]           cpu_rdata_q, cpu_rdata_d;
   logic [FETCH_LAT-1:0] char_pipe_q, char_pipe_d;
   logic [FETCH_LAT-1:0] att_pipe_q, att_pipe_d;
   logic                 hres_q, hres_d;
   logic                 grph_q, grph_d;

   logic        is_char, is_att, is_hi;
   logic [4:0]  seq_next;
   logic        snow_next, grant_next;
   logic [12:0] base_addr;
   logic [13:0] disp_addr;
   logic        row_unused;

   assign row_unused = &{1'b0, row_addr[4:1]};

   always_comb begin
      is_char   = (clk_seq == F0) || (hres_q && (clk_seq == H0));
      is_att    = (clk_seq == F1) || (hres_q && (clk_seq == H1));
      is_hi     = hres_q && ((clk_seq == H0) || (clk_seq == H1));
      base_addr = is_hi ? (crtc_addr + 13'd1) : crtc_addr;
      disp_addr = grph_q ? {row_addr[0], base_addr[11:0], is_att}
                         : {base_addr, is_att};
      seq_next  = clk_seq + 5'd1;
`ifdef CGA_SNOW_EN
      snow_next = hres_q && !grph_q && ((seq_next == F0) || (seq_next == H0));
`else
      snow_next = 1'b0;
`endif
      // Decide one cycle ahead so ISSUE lands exactly on the granted slot.
      grant_next = !slot_reserved(seq_next, SLOT_CHAR, hres_q) || snow_next;
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      we_d        = we_q;
      wdata_d     = wdata_q;
      cpu_rdata_d = cpu_rdata_q;
      unique case (state_q)
         ST_IDLE, ST_ACK: begin
            state_d = ST_IDLE;
            if (cpu_req) begin
               state_d = ST_WAIT;
               addr_d  = cpu_addr;
               we_d    = cpu_we;
               wdata_d = cpu_wdata;
            end
         end
         ST_WAIT:  if (grant_next) state_d = ST_ISSUE;
         ST_ISSUE: state_d = ST_LAT;
         ST_LAT: begin
            state_d = ST_ACK;
            // Loads the same byte vram_data takes, so rdata is valid with ack.
            if (!we_q) cpu_rdata_d = vram_data_d;
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      vram_data_d = ram_rdata;
      char_pipe_d = {char_pipe_q[FETCH_LAT-2:0], is_char};
      att_pipe_d  = {att_pipe_q[FETCH_LAT-2:0], is_att};
      hres_d      = hres_mode;
      grph_d      = grph_mode;
   end

   always_comb begin
      ram_addr  = '0;
      ram_we    = 1'b0;
      ram_wdata = 8'h00;
      if (!reset) begin
         if (state_q == ST_ISSUE) begin
            ram_addr  = addr_q;
            ram_we    = we_q;
            ram_wdata = wdata_q;
         end else if (is_char || is_att) begin
            ram_addr = ADDR_W'(disp_addr);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         we_q        <= 1'b0;
         wdata_q     <= 8'h00;
         vram_data_q <= 8'h00;
         cpu_rdata_q <= 8'h00;
         char_pipe_q <= '0;
         att_pipe_q  <= '0;
         hres_q      <= 1'b0;
         grph_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         wdata_q     <= wdata_d;
         vram_data_q <= vram_data_d;
         cpu_rdata_q <= cpu_rdata_d;
         char_pipe_q <= char_pipe_d;
         att_pipe_q  <= att_pipe_d;
         hres_q      <= hres_d;
         grph_q      <= grph_d;
      end
   end

   assign cpu_busy       = !reset && ((state_q == ST_WAIT) || (state_q == ST_ISSUE) ||
                                      (state_q == ST_LAT));
   assign cpu_ack        = !reset && (state_q == ST_ACK);
   assign cpu_rdata      = cpu_rdata_q;
   assign vram_data      = vram_data_q;
   assign vram_read_char = char_pipe_q[FETCH_LAT-1];
   assign vram_read_att  = att_pipe_q[FETCH_LAT-1];

endmodule

`default_nettype wire

// File: tb/tb_cga_vram_fetch.sv
// ============================================================================
// tb_cga_vram_fetch : directed self-checking bench for cga_vram_fetch.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cga_vram_fetch;

   localparam int ADDR_W = 14;
`ifdef CGA_SNOW_EN
   localparam logic [4:0] ISSUE_SEQ = 5'd16;
   localparam logic [7:0] CHAR18    = 8'hC3;
`else
   localparam logic [4:0] ISSUE_SEQ = 5'd18;
   localparam logic [7:0] CHAR18    = 8'h42;
`endif
   localparam logic [4:0]  ACK_SEQ = ISSUE_SEQ + 5'd2;
   localparam logic [13:0] HI_ADDR = (ISSUE_SEQ == 5'd16) ? 14'h0240 : 14'h0022;

   logic              clk = 1'b0;
   logic              reset;
   logic [4:0]        clk_seq;
   logic              hres_mode, grph_mode;
   logic [12:0]       crtc_addr;
   logic [4:0]        row_addr;
   logic              cpu_req, cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [7:0]        cpu_wdata;
   logic              cpu_busy, cpu_ack;
   logic [7:0]        cpu_rdata;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic [7:0]        ram_wdata;
   logic [7:0]        ram_rdata;
   logic [7:0]        vram_data;
   logic              vram_read_char, vram_read_att;

   logic [7:0] mem [0:16383];
   logic       mem_init;
   int         n_checks = 0;
   int         n_errors = 0;
   int         acks;

   cga_vram_fetch #(.SLOT_CHAR(5'd0), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset), .clk_seq(clk_seq),
      .hres_mode(hres_mode), .grph_mode(grph_mode),
      .crtc_addr(crtc_addr), .row_addr(row_addr),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_busy(cpu_busy), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .vram_data(vram_data), .vram_read_char(vram_read_char), .vram_read_att(vram_read_att)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] init_byte(input int a);
      case (a)
         'h0020:  return 8'h41;
         'h0021:  return 8'h1E;
         'h0022:  return 8'h42;
         'h0200:  return 8'h5C;
         'h0240:  return 8'hC3;
         default: return 8'h00;
      endcase
   endfunction

   // Synchronous VRAM: read data valid one clock after the address.
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 16384; i++) mem[i] <= init_byte(i);
      end else if (ram_we) begin
         mem[ram_addr] <= ram_wdata;
      end
      ram_rdata <= mem[ram_addr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      clk_seq = clk_seq + 5'd1;
   endtask

   task automatic goto_seq(input logic [4:0] n);
      while (clk_seq != n) cyc();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; mem_init = 1'b1; clk_seq = 5'd0;
      hres_mode = 1'b0; grph_mode = 1'b0; crtc_addr = 13'h0010; row_addr = 5'd0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = 8'h00;
      repeat (3) cyc();
      @(negedge clk);
      check("rst_ram_we",    32'(ram_we), 32'd0);
      check("rst_cpu_ack",   32'(cpu_ack), 32'd0);
      check("rst_cpu_busy",  32'(cpu_busy), 32'd0);
      check("rst_read_char", 32'(vram_read_char), 32'd0);
      check("rst_read_att",  32'(vram_read_att), 32'd0);
      check("rst_ram_addr",  32'(ram_addr), 32'd0);
      check("rst_vram_data", 32'(vram_data), 32'd0);
      check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
      reset = 1'b0; mem_init = 1'b0;

      // Text-mode char/attribute fetch
      goto_seq(5'd0);
      @(negedge clk); check("txt_char_addr", 32'(ram_addr), 32'h0020);
      cyc(); @(negedge clk); check("txt_att_addr", 32'(ram_addr), 32'h0021);
      cyc(); @(negedge clk);
      check("txt_char_stb", 32'(vram_read_char), 32'd1);
      check("txt_att_stb0", 32'(vram_read_att), 32'd0);
      check("txt_char_data", 32'(vram_data), 32'h41);
      cyc(); @(negedge clk);
      check("txt_att_stb", 32'(vram_read_att), 32'd1);
      check("txt_att_data", 32'(vram_data), 32'h1E);

      // CPU write requested in a reserved slot
      goto_seq(5'd0);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0100; cpu_wdata = 8'hAA;
      cyc(); cpu_req = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("wr_we", 32'(ram_we), 32'(clk_seq == 5'd2));
         check("wr_ack", 32'(cpu_ack), 32'(clk_seq == 5'd4));
         if (clk_seq == 5'd1) begin
            check("wr_busy", 32'(cpu_busy), 32'd1);
            check("wr_att_kept", 32'(ram_addr), 32'h0021);
         end
         if (clk_seq == 5'd2) begin
            check("wr_addr", 32'(ram_addr), 32'h0100);
            check("wr_char_kept", 32'(vram_read_char), 32'd1);
            check("wr_char_data", 32'(vram_data), 32'h41);
         end
         cyc();
      end
      check("wr_mem", 32'(mem[14'h0100]), 32'hAA);
      cpu_we = 1'b0;

      // CPU read in a free slot
      goto_seq(5'd8);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0200;
      cyc(); cpu_req = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("rd_ack", 32'(cpu_ack), 32'(clk_seq == 5'd12));
         if (clk_seq == 5'd9)  check("rd_busy", 32'(cpu_busy), 32'd1);
         if (clk_seq == 5'd12) begin
            check("rd_data", 32'(cpu_rdata), 32'h5C);
            check("rd_busy_drop", 32'(cpu_busy), 32'd0);
         end
         if (clk_seq == 5'd13) check("rd_hold", 32'(cpu_rdata), 32'h5C);
         cyc();
      end

      // Back-to-back: second request while busy is dropped
      goto_seq(5'd8);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0300; cpu_wdata = 8'h33;
      cyc();
      cpu_addr = 14'h0301; cpu_wdata = 8'h77;
      cyc(); cpu_req = 1'b0; cpu_we = 1'b0;
      acks = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (cpu_ack) acks++;
         cyc();
      end
      check("b2b_acks", 32'(acks), 32'd1);
      check("b2b_mem_first", 32'(mem[14'h0300]), 32'h33);
      check("b2b_mem_second", 32'(mem[14'h0301]), 32'h00);
      check("b2b_rdata_hold", 32'(cpu_rdata), 32'h5C);

      // High-resolution text: second fetch pair and CPU slot placement
      hres_mode = 1'b1;
      cyc();
      goto_seq(5'd14);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0240;
      cyc(); cpu_req = 1'b0;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         check("hr_ack", 32'(cpu_ack), 32'(clk_seq == ACK_SEQ));
         if (clk_seq == 5'd16)     check("hr_slot16_addr", 32'(ram_addr), 32'(HI_ADDR));
         if (clk_seq == 5'd17)     check("hr_att_addr", 32'(ram_addr), 32'h0023);
         if (clk_seq == ISSUE_SEQ) check("hr_issue_addr", 32'(ram_addr), 32'h0240);
         if (clk_seq == 5'd18) begin
            check("hr_char_stb", 32'(vram_read_char), 32'd1);
            check("hr_char_data", 32'(vram_data), 32'(CHAR18));
         end
         if (clk_seq == ACK_SEQ)   check("hr_rdata", 32'(cpu_rdata), 32'hC3);
         cyc();
      end
      hres_mode = 1'b0;
      cyc();

      // Reset asserted while the write is in ISSUE
      goto_seq(5'd8);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0500; cpu_wdata = 8'h99;
      cyc(); cpu_req = 1'b0; cpu_we = 1'b0;
      cyc();
      reset = 1'b1;
      @(negedge clk); check("rsti_we_in_reset", 32'(ram_we), 32'd0);
      cyc(); reset = 1'b0;
      @(negedge clk);
      check("rsti_we_after", 32'(ram_we), 32'd0);
      check("rsti_busy", 32'(cpu_busy), 32'd0);
      acks = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (cpu_ack) acks++;
         cyc();
      end
      check("rsti_no_ack", 32'(acks), 32'd0);
      check("rsti_mem", 32'(mem[14'h0500]), 32'h00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
